// File: rtl/phy_rx_align.sv
`timescale 1ns/1ps
// Serial-to-parallel receiver that hunts for a comma, confirms word alignment, then emits words.
// Latency: data_out/word_strobe register on the enabled edge that captures a word's last bit.
// Backpressure: none; enable low freezes the shifter and FSM, which is the only stall.
module phy_rx_align #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 'hBC,
  parameter int               SYNC_COUNT = 4,
  parameter int               LOSS_COUNT = 4
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             enable,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             word_strobe,
  output logic             active,
  output logic             loss_of_sync
);

  localparam int BW = $clog2(WIDTH);
  localparam int SW = $clog2(SYNC_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [SW-1:0] SYNC_MAX = SW'(SYNC_COUNT);
  localparam logic [MW-1:0] LOSS_MAX = MW'(LOSS_COUNT);

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]    bit_cnt, bit_nxt;
  logic [SW-1:0]    sync_cnt, sync_nxt, sync_inc;
  logic [MW-1:0]    miss_cnt, miss_nxt, miss_inc;
  logic [WIDTH-1:0] window;
  logic             is_comma;
  logic             boundary;
  logic             load_word;
  logic             lose;

  // The window includes the bit arriving on this edge, so a comma is seen the edge it completes.
  assign window   = {sr[WIDTH-2:0], serial_in};
  assign is_comma = (window == COMMA);
  assign boundary = (bit_cnt == BIT_LAST);
  assign sync_inc = (sync_cnt == SYNC_MAX) ? sync_cnt : sync_cnt + SW'(1);
  assign miss_inc = (miss_cnt == LOSS_MAX) ? miss_cnt : miss_cnt + MW'(1);

  // Next-state, counter updates and word/loss events; nothing moves while enable is low.
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    sync_nxt  = sync_cnt;
    miss_nxt  = miss_cnt;
    load_word = 1'b0;
    lose      = 1'b0;
    if (enable) begin
      bit_nxt = boundary ? '0 : bit_cnt + BW'(1);
      case (state)
        SEARCH: begin
          if (is_comma) begin
            // Comma just completed: the next bit starts a word.
            bit_nxt   = '0;
            sync_nxt  = SW'(1);
            state_nxt = (SYNC_COUNT == 1) ? ACTIVE : ALIGN;
          end
        end
        ALIGN: begin
          if (boundary) begin
            if (is_comma) begin
              sync_nxt = sync_inc;
              if (sync_inc == SYNC_MAX) state_nxt = ACTIVE;
            end else begin
              sync_nxt  = '0;
              state_nxt = SEARCH;
            end
          end
        end
        ACTIVE: begin
          if (boundary) begin
            load_word = 1'b1;
            if (is_comma) miss_nxt = '0;
          end else if (is_comma) begin
            // A comma off the word grid means the stream has slipped.
            if (miss_inc == LOSS_MAX) begin
              miss_nxt  = '0;
              lose      = 1'b1;
              state_nxt = SEARCH;
            end else begin
              miss_nxt = miss_inc;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_8f) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  // Shifter, counters and registered outputs.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      sr           <= '0;
      bit_cnt      <= '0;
      sync_cnt     <= '0;
      miss_cnt     <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      word_strobe  <= 1'b0;
      active       <= 1'b0;
      loss_of_sync <= 1'b0;
    end else begin
      if (enable) sr <= window;
      bit_cnt      <= bit_nxt;
      sync_cnt     <= sync_nxt;
      miss_cnt     <= miss_nxt;
      word_strobe  <= load_word;
      loss_of_sync <= lose;
      active       <= (state_nxt == ACTIVE);
      if (load_word) begin
        data_out  <= window;
        valid_out <= ~is_comma;
      end else if (lose) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule
